// File: rtl/serial_pkg.sv
// Shared types and constants for the serial byte transmitter.
// Optional feature macro used by this slice: SERIAL_TX_PARITY_EN.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity bit: XOR of all data bits, same rule as the upstream parity generator.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/serial_byte_tx_baud_tick_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled, strobes bit_end on the last count.
// Cleared synchronously when a byte is accepted so every frame starts on a fresh bit time.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_bit_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == LAST_CNT);
    assign o_bit_end = i_en && w_last;

    // Count clock cycles within the current bit, wrapping to 0 at each bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to compile in the parity bit (11-bit frame); otherwise 8N1.
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_e            r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [2:0]           r_idx,   w_idx_nxt;
    logic                 r_tx,    w_tx_nxt;
    logic                 r_busy,  w_busy_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_done,  w_done_nxt;
`ifdef SERIAL_TX_PARITY_EN
    logic                 r_parity, w_parity_nxt;
`endif

    logic w_accept;
    logic w_bit_end;

    assign w_accept = (r_state == IDLE) && din_valid && r_ready;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_accept),
        .i_en     (r_busy),
        .o_bit_end(w_bit_end)
    );

    // State and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_ready  <= w_ready_nxt;
            r_done   <= w_done_nxt;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    // Next state and next output levels; each bit is held until the bit-time strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_idx;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_ready_nxt  = r_ready;
        w_done_nxt   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_tx_nxt    = IDLE_LEVEL;
                w_busy_nxt  = 1'b0;
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt  = START;
                    w_shift_nxt  = din;
                    w_idx_nxt    = '0;
                    w_tx_nxt     = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_ready_nxt  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    w_parity_nxt = even_parity(din);
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_tx_nxt    = IDLE_LEVEL;
                    w_busy_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = IDLE_LEVEL;
                w_busy_nxt  = 1'b0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    assign din_ready = r_ready;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign tx_done   = r_done;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Self-checking bench for serial_byte_tx with CLKS_PER_BIT=4 and random bytes.
// Frame length follows SERIAL_TX_PARITY_EN the same way the design does.
module tb_serial_byte_tx;

    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int total = 0;
    int bad   = 0;

    serial_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Reference frame: bit 0 start (0), bits 1..8 data LSB first, then even parity if enabled, then stop (1).
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int ones;
        if (i == 0) return 1'b0;
        if (i >= 1 && i <= 8) return b[i-1];
        if (NBITS == 11 && i == 9) begin
            ones = 0;
            for (int j = 0; j < 8; j++) ones += b[j];
            return (ones % 2 == 1);
        end
        return 1'b1;
    endfunction

    // Present a byte and wait (bounded) until it is accepted; returns at the negedge after acceptance.
    task automatic accept_byte(input logic [7:0] b, input bit keep_valid);
        int n = 0;
        din       = b;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (din_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout byte=%h: ready=%b want 1", b, din_ready);
        end
        @(negedge clk);
        if (!keep_valid) din_valid = 1'b0;
    endtask

    // Check every sample of a frame against the reference, then the tx_done sample.
    task automatic check_frame(input logic [7:0] b, input bit noise, output int ones);
        logic exp;
        ones = 0;
        for (int k = 0; k < NBITS * CPB; k++) begin
            if (k > 0) @(negedge clk);
            exp = frame_bit(b, k / CPB);
            total++;
            if (tx !== exp) begin
                bad++;
                $display("FAIL frame_tx byte=%h sample=%0d: got %b want %b", b, k, tx, exp);
            end
            total++;
            if ({busy, din_ready, tx_done} !== 3'b100) begin
                bad++;
                $display("FAIL frame_status byte=%h sample=%0d: busy/ready/done got %b want 100",
                         b, k, {busy, din_ready, tx_done});
            end
            if (k % CPB == 0 && k / CPB >= 1 && k / CPB <= NBITS - 2) ones += int'(tx);
            if (noise) begin
                if (k == NBITS * CPB - 1) begin
                    din_valid = 1'b0;
                end else begin
                    din       = 8'($urandom);
                    din_valid = 1'($urandom_range(0, 1));
                end
            end
        end
        @(negedge clk);
        total++;
        if ({tx_done, busy, din_ready, tx} !== 4'b1011) begin
            bad++;
            $display("FAIL frame_end byte=%h: done/busy/ready/tx got %b want 1011",
                     b, {tx_done, busy, din_ready, tx});
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({tx, busy, din_ready, tx_done} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_values: tx/busy/ready/done got %b want 1000",
                     {tx, busy, din_ready, tx_done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (din_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise: got %b want 1", din_ready);
        end
    endtask

    task automatic test_single();
        int ones;
        accept_byte(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, ones);
        @(negedge clk);
        total++;
        if (tx_done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle: got %b want 0", tx_done);
        end
    endtask

    task automatic test_odd_ones();
        int ones;
`ifdef SERIAL_TX_PARITY_EN
        int exp_ones = 4;
`else
        int exp_ones = 3;
`endif
        accept_byte(8'h07, 1'b0);
        check_frame(8'h07, 1'b0, ones);
        total++;
        if (ones != exp_ones) begin
            bad++;
            $display("FAIL odd_ones_count: got %0d want %0d", ones, exp_ones);
        end
    endtask

    task automatic test_random();
        int ones;
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept_byte(b, 1'b0);
            check_frame(b, 1'b0, ones);
        end
    endtask

    task automatic test_back_to_back();
        int ones;
        @(negedge clk);
        accept_byte(8'h00, 1'b1);
        din = 8'hFF;
        check_frame(8'h00, 1'b0, ones);
        // Still in the tx_done cycle: valid is high, so the next edge accepts 8'hFF.
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if ({tx, busy, din_ready} !== 3'b010) begin
            bad++;
            $display("FAIL b2b_second_start: tx/busy/ready got %b want 010", {tx, busy, din_ready});
        end
        check_frame(8'hFF, 1'b0, ones);
    endtask

    task automatic test_ignored();
        int ones;
        logic [7:0] b;
        b = 8'($urandom);
        @(negedge clk);
        accept_byte(b, 1'b0);
        check_frame(b, 1'b1, ones);
    endtask

    task automatic test_midframe_reset();
        int ones;
        @(negedge clk);
        accept_byte(8'hC3, 1'b0);
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx, busy, din_ready, tx_done} !== 4'b1000) begin
            bad++;
            $display("FAIL midreset_immediate: tx/busy/ready/done got %b want 1000",
                     {tx, busy, din_ready, tx_done});
        end
        repeat (2) @(negedge clk);
        total++;
        if ({tx, busy} !== 2'b10) begin
            bad++;
            $display("FAIL midreset_hold: tx/busy got %b want 10", {tx, busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
        accept_byte(8'h3C, 1'b0);
        check_frame(8'h3C, 1'b0, ones);
    endtask

    initial begin
        test_reset();
        test_single();
        test_odd_ones();
        test_random();
        test_back_to_back();
        test_ignored();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
